// File: rtl/pass_pkg.sv
// Shared types, default parameters and width helpers for the passcode memory.
package pass_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_RESULT  = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_e;

  localparam int unsigned DEF_DW          = 4;
  localparam int unsigned DEF_AW          = 4;
  localparam int unsigned DEF_CODE_LEN    = 4;
  localparam int unsigned DEF_MAX_FAIL    = 3;
  localparam int unsigned DEF_LOCK_CYCLES = 16;
  localparam bit          DEF_UNLOCK_RST  = 1'b1;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned ctr_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Slot index width; a single slot still gets a one-bit index.
  function automatic int unsigned slot_width(input int unsigned aw, input int unsigned cl);
    return ($clog2(cl) >= aw) ? 1 : (aw - $clog2(cl));
  endfunction

endpackage

// File: rtl/pass_mem_array.sv
// Storage array: one write port, one registered read port, one combinational
// compare-read port used by the digit engine.
module pass_mem_array
  import pass_pkg::*;
#(
  parameter int unsigned DW = DEF_DW,
  parameter int unsigned AW = DEF_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  input  logic [AW-1:0] cmp_addr,
  output logic [DW-1:0] cmp_data_c
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [DW-1:0] mem [DEPTH];

  // Write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port; a same-address write in the same cycle returns old data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= mem[rd_addr];
      end
    end
  end

  // Compare read sees the pre-write value of the current cycle.
  assign cmp_data_c = mem[cmp_addr];

endmodule

// File: rtl/pass_mem.sv
// Passcode-protected memory: writes are allowed only after a matching code
// has been entered; repeated failures trigger a timed lockout.
module pass_mem
  import pass_pkg::*;
#(
  parameter int unsigned DW          = DEF_DW,
  parameter int unsigned AW          = DEF_AW,
  parameter int unsigned CODE_LEN    = DEF_CODE_LEN,
  parameter int unsigned MAX_FAIL    = DEF_MAX_FAIL,
  parameter int unsigned LOCK_CYCLES = DEF_LOCK_CYCLES,
  parameter bit          UNLOCK_RST  = DEF_UNLOCK_RST
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                wr_en,
  input  logic [AW-1:0]                       wr_addr,
  input  logic [DW-1:0]                       wr_data,
  input  logic                                rd_en,
  input  logic [AW-1:0]                       rd_addr,
  output logic [DW-1:0]                       rd_data,
  output logic                                rd_valid,
  input  logic                                cmp_start,
  input  logic [slot_width(AW, CODE_LEN)-1:0] cmp_slot,
  input  logic                                dig_valid,
  input  logic [DW-1:0]                       dig_data,
  output logic                                dig_ready,
  output logic                                match,
  output logic                                fail,
  output logic                                unlocked,
  output logic                                locked_out,
  input  logic                                relock
);

  localparam int unsigned SW  = slot_width(AW, CODE_LEN);
  localparam int unsigned CLW = $clog2(CODE_LEN);
  localparam int unsigned IW  = ctr_width(CODE_LEN);
  localparam int unsigned FW  = ctr_width(MAX_FAIL + 1);
  localparam int unsigned TW  = ctr_width(LOCK_CYCLES + 1);

  state_e         state_q, state_d;
  logic [SW-1:0]  slot_q, slot_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           err_q, err_d;
  logic [FW-1:0]  fail_cnt_q, fail_cnt_d;
  logic [TW-1:0]  timer_q, timer_d;

  logic           match_d, fail_d, dig_ready_d, locked_out_d, unlocked_d;

  logic           mem_we_c;
  logic [AW-1:0]  cmp_addr_c;
  logic [DW-1:0]  cmp_data_c;
  logic [FW-1:0]  fail_inc_c;

  assign mem_we_c   = wr_en && unlocked;
  assign cmp_addr_c = AW'(AW'(slot_q) << CLW) | AW'(idx_q);
  assign fail_inc_c = fail_cnt_q + FW'(1);

  pass_mem_array #(
    .DW (DW),
    .AW (AW)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (mem_we_c),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .cmp_addr   (cmp_addr_c),
    .cmp_data_c (cmp_data_c)
  );

  // State, engine datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      slot_q     <= '0;
      idx_q      <= '0;
      err_q      <= 1'b0;
      fail_cnt_q <= '0;
      timer_q    <= '0;
      match      <= 1'b0;
      fail       <= 1'b0;
      dig_ready  <= 1'b0;
      locked_out <= 1'b0;
      unlocked   <= UNLOCK_RST;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      idx_q      <= idx_d;
      err_q      <= err_d;
      fail_cnt_q <= fail_cnt_d;
      timer_q    <= timer_d;
      match      <= match_d;
      fail       <= fail_d;
      dig_ready  <= dig_ready_d;
      locked_out <= locked_out_d;
      unlocked   <= unlocked_d;
    end
  end

  // Next-state and engine datapath decode.
  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    idx_d      = idx_q;
    err_d      = err_q;
    fail_cnt_d = fail_cnt_q;
    timer_d    = timer_q;
    case (state_q)
      ST_IDLE: begin
        if (cmp_start) begin
          slot_d  = cmp_slot;
          idx_d   = '0;
          err_d   = 1'b0;
          state_d = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (dig_valid) begin
          if (dig_data != cmp_data_c) begin
            err_d = 1'b1;
          end
          idx_d = idx_q + IW'(1);
          if (idx_q == IW'(CODE_LEN - 1)) begin
            state_d = ST_RESULT;
          end
        end
      end
      ST_RESULT: begin
        if (err_q) begin
          if (fail_inc_c == FW'(MAX_FAIL)) begin
            fail_cnt_d = '0;
            timer_d    = TW'(LOCK_CYCLES);
            state_d    = ST_LOCKOUT;
          end else begin
            fail_cnt_d = fail_inc_c;
            state_d    = ST_IDLE;
          end
        end else begin
          fail_cnt_d = '0;
          state_d    = ST_IDLE;
        end
      end
      ST_LOCKOUT: begin
        if (timer_q <= TW'(1)) begin
          timer_d = '0;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so each flop lines up with its state.
  always_comb begin
    match_d      = 1'b0;
    fail_d       = 1'b0;
    dig_ready_d  = 1'b0;
    locked_out_d = 1'b0;
    unlocked_d   = unlocked;
    case (state_d)
      ST_COLLECT: dig_ready_d  = 1'b1;
      ST_RESULT: begin
        match_d = !err_d;
        fail_d  = err_d;
      end
      ST_LOCKOUT: locked_out_d = 1'b1;
      default: ;
    endcase
    if (relock) begin
      unlocked_d = 1'b0;
    end else if (state_q == ST_RESULT && !err_q) begin
      unlocked_d = 1'b1;
    end
  end

endmodule

// File: doc/pass_mem.md
PASS_MEM -- requirements
Module: pass_mem

Interface
REQ-001 Parameter: DW, 4, digit/data width in bits.
REQ-002 Parameter: AW, 4, address width; array depth is 2**AW.
REQ-003 Parameter: CODE_LEN, 4, digits per code slot; power of two, at most 2**AW.
REQ-004 Parameter: MAX_FAIL, 3, consecutive failed compares that trigger lockout; at least 1.
REQ-005 Parameter: LOCK_CYCLES, 16, lockout duration in clk cycles; at least 1.
REQ-006 Parameter: UNLOCK_RST, 1, reset value of unlocked.
REQ-007 Derived: SW = AW - clog2(CODE_LEN), slot index width; slot s occupies addresses s*CODE_LEN .. s*CODE_LEN+CODE_LEN-1.
REQ-008 Clocking: one clock; reset is synchronous and active-high.
REQ-009 clk  in  1  sole clock; all state updates on its rising edge.
REQ-010 rst  in  1  synchronous active-high reset.
REQ-011 wr_en  in  1  write strobe.
REQ-012 wr_addr  in  AW  write address.
REQ-013 wr_data  in  DW  write data.
REQ-014 rd_en  in  1  read strobe.
REQ-015 rd_addr  in  AW  read address.
REQ-016 rd_data  out  DW  registered read data.
REQ-017 rd_valid  out  1  one-cycle pulse; rd_data is valid.
REQ-018 cmp_start  in  1  begin compare against slot cmp_slot.
REQ-019 cmp_slot  in  SW  slot to compare.
REQ-020 dig_valid / dig_data  in  1 / DW  entered digit plus qualifier.
REQ-021 dig_ready  out  1  engine accepts a digit this cycle.
REQ-022 match / fail  out  1 / 1  one-cycle compare result pulses.
REQ-023 unlocked  out  1  writes permitted.
REQ-024 locked_out  out  1  lockout active.
REQ-025 relock  in  1  clears unlocked.

Function
REQ-026 Memory write occurs only when wr_en=1 and unlocked=1; otherwise the write is dropped silently.
REQ-027 Read: rd_en in cycle N drives rd_data=mem[rd_addr] and rd_valid=1 in cycle N+1; rd_data holds its value otherwise; read-during-write to the same address returns old data.
REQ-028 FSM states: IDLE, COLLECT, RESULT, LOCKOUT.
REQ-029 IDLE: dig_ready=0; cmp_start=1 latches cmp_slot, clears idx and err, then goes to COLLECT.
REQ-030 COLLECT: dig_ready=1; each cycle with dig_valid=1 compares dig_data to mem[slot*CODE_LEN+idx] (pre-write value), sets err on mismatch, and increments idx.
REQ-031 COLLECT exit: acceptance of digit CODE_LEN-1 moves to RESULT; cmp_start in COLLECT is ignored.
REQ-032 RESULT (one cycle), err=0: match=1, fail_cnt=0, unlocked=1, next state IDLE.
REQ-033 RESULT, err=1: fail=1, fail_cnt+1; if the new count equals MAX_FAIL, fail_cnt=0, timer=LOCK_CYCLES, next state LOCKOUT; otherwise next state IDLE.
REQ-034 LOCKOUT: locked_out=1, dig_ready=0, cmp_start ignored, timer decrements each cycle, and the cycle with timer=1 returns to IDLE; locked_out is high for exactly LOCK_CYCLES cycles.
REQ-035 relock=1 clears unlocked the next cycle; relock wins over a simultaneous match.
REQ-036 Read and write ports stay operational in all FSM states, including LOCKOUT.
REQ-037 fail_cnt is clog2(MAX_FAIL+1) bits wide and never exceeds MAX_FAIL-1 outside RESULT.

Reset
REQ-038 rst forces state=IDLE, idx=0, err=0, fail_cnt=0, timer=0, rd_data=0, rd_valid=0, match=0, fail=0, dig_ready=0, locked_out=0, unlocked=UNLOCK_RST.
REQ-039 Memory contents are not cleared by rst.
REQ-040 rst asserted mid-COLLECT or mid-LOCKOUT aborts the operation with no match/fail pulse.

Structure
REQ-041 Package pass_pkg holds the FSM state enum and default parameter constants.
REQ-042 Sub-module pass_mem_array holds the storage: one write port, one registered read port, one combinational compare-read port.

Verification
REQ-043 Defaults, after reset: write slot 2 (addr 8..11) = 1,9,13,8, relock, compare slot 2 with 1,9,13,8 -> match pulse, unlocked=1.
REQ-044 Compare slot 2 with 1,9,13,7 three consecutive times -> fail pulse each time; locked_out high exactly 16 cycles after the third RESULT; cmp_start during lockout ignored.
REQ-045 With unlocked=0, wr_en addr 5 data 4'hA -> rd_en addr 5 returns the previous value one cycle later with rd_valid=1.
REQ-046 wr_en and rd_en both at addr 3 in the same cycle (old 4'h1, new 4'hC) -> rd_data=4'h1; next read returns 4'hC.
REQ-047 Two fails, then a match, then one fail -> no lockout (fail_cnt was reset by the match).
REQ-048 rst asserted after 2 digits in COLLECT -> IDLE, no match/fail pulse, unlocked=1 (UNLOCK_RST), memory intact.
